// File: rtl/audio_slot_scheduler.sv
// audio_slot_scheduler: packs RF words with a framed PCM/ADC side-channel carried in bits [15:10]
module audio_slot_scheduler #(
  parameter int FRAME_LEN  = 512,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [9:0]            rf_in,
  input  logic                  rf_valid,
  input  logic [23:0]           pcm_left,
  input  logic [23:0]           pcm_right,
  input  logic                  pcm_ready,
  input  logic [11:0]           adc_left,
  input  logic [11:0]           adc_right,
  input  logic                  adc_ready,
  output logic [15:0]           data_out,
  output logic                  data_valid,
  output logic                  frame_start,
  output logic                  pcm_overrun,
  output logic                  adc_overrun,
  output logic [DROP_CNT_W-1:0] drop_count
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [1:0] IDLE = 2'd0, HEAD = 2'd1, PAYLOAD = 2'd2, FILL = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [3:0] seq;
  logic [23:0] pcm_l_h, pcm_r_h;
  logic [11:0] adc_l_h, adc_r_h;
  logic pcm_pend, adc_pend;
  logic [71:0] snap, sh;
  logic pcm_fresh, adc_fresh, pcm_ovr_f, adc_ovr_f;
  logic emit, snap_now, pcm_ovr_ev, adc_ovr_ev;
  logic [5:0] chunk, csum, c1;
  logic [DROP_CNT_W:0] drop_sum;
  int idx;
  assign emit       = enable && state != IDLE && rf_valid;
  assign snap_now   = emit && state == HEAD;
  assign pcm_ovr_ev = pcm_ready && pcm_pend && !snap_now;
  assign adc_ovr_ev = adc_ready && adc_pend && !snap_now;
  assign drop_sum   = {1'b0, drop_count} + (DROP_CNT_W+1)'(pcm_ovr_ev) + (DROP_CNT_W+1)'(adc_ovr_ev);
  assign c1         = {pcm_fresh, adc_fresh, pcm_ovr_f, adc_ovr_f, 2'b00};
  // snap holds chunks 2..13 with chunk 2 in the top bits
  always_comb begin
    idx = int'(cnt);
    sh = snap >> (6 * (13 - idx));
    csum = {2'b10, seq} ^ c1;
    for (int i = 0; i < 12; i++) csum = csum ^ snap[6*i +: 6];
    chunk = idx == 0 ? {2'b10, seq} :
            idx == 1 ? c1 :
            idx < 14 ? sh[5:0] :
            idx == 14 ? csum : 6'd0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      seq <= '0;
      {pcm_l_h, pcm_r_h, adc_l_h, adc_r_h} <= '0;
      {pcm_pend, adc_pend} <= '0;
      snap <= '0;
      {pcm_fresh, adc_fresh, pcm_ovr_f, adc_ovr_f} <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_start <= 1'b0;
      pcm_overrun <= 1'b0;
      adc_overrun <= 1'b0;
      drop_count <= '0;
    end else begin
      if (pcm_ready) {pcm_l_h, pcm_r_h} <= {pcm_left, pcm_right};
      if (adc_ready) {adc_l_h, adc_r_h} <= {adc_left, adc_right};
      pcm_pend <= pcm_ready || (pcm_pend && !snap_now);
      adc_pend <= adc_ready || (adc_pend && !snap_now);
      pcm_overrun <= pcm_overrun || pcm_ovr_ev;
      adc_overrun <= adc_overrun || adc_ovr_ev;
      drop_count <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
      data_valid <= emit;
      frame_start <= snap_now;
      if (emit) data_out <= {chunk, rf_in};
      // stale sources keep their previous snapshot data
      if (snap_now) begin
        {pcm_fresh, adc_fresh, pcm_ovr_f, adc_ovr_f} <= {pcm_pend, adc_pend, pcm_overrun, adc_overrun};
        if (pcm_pend) snap[71:24] <= {pcm_l_h, pcm_r_h};
        if (adc_pend) snap[23:0] <= {adc_l_h, adc_r_h};
      end
      if (!enable) begin
        state <= IDLE;
        cnt <= '0;
      end else if (state == IDLE) begin
        state <= HEAD;
      end else if (rf_valid) begin
        cnt <= cnt + 1'b1;
        state <= (&cnt) ? HEAD : (cnt == CW'(15)) ? FILL : (state == HEAD) ? PAYLOAD : state;
        if (&cnt) seq <= seq + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_audio_slot_scheduler.sv
// tb_audio_slot_scheduler: directed checks of framing, audio packing, overruns and flow control
module tb_audio_slot_scheduler;
  logic clock = 1'b0, reset, enable, rf_valid, pcm_ready, adc_ready;
  logic [9:0] rf_in;
  logic [23:0] pcm_left, pcm_right;
  logic [11:0] adc_left, adc_right;
  logic [15:0] data_out;
  logic data_valid, frame_start, pcm_overrun, adc_overrun;
  logic [7:0] drop_count;
  int tests = 0, fails = 0, shown = 0, nxt = 0;

  audio_slot_scheduler dut (
    .clock(clock), .reset(reset), .enable(enable), .rf_in(rf_in), .rf_valid(rf_valid),
    .pcm_left(pcm_left), .pcm_right(pcm_right), .pcm_ready(pcm_ready),
    .adc_left(adc_left), .adc_right(adc_right), .adc_ready(adc_ready),
    .data_out(data_out), .data_valid(data_valid), .frame_start(frame_start),
    .pcm_overrun(pcm_overrun), .adc_overrun(adc_overrun), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
    if (data_valid) begin
      shown = nxt;
      nxt = (nxt + 1) % 512;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic goto(input int w);
    int n;
    n = 0;
    step();
    while (!(data_valid && shown == w) && n < 2000) begin
      step();
      n++;
    end
    tests++;
    assert (data_valid && shown == w) else begin
      fails++;
      $error("FAIL goto observed word %0d expected word %0d", shown, w);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; rf_valid = 1'b0; rf_in = 10'h155;
    pcm_ready = 1'b0; adc_ready = 1'b0;
    pcm_left = '0; pcm_right = '0; adc_left = '0; adc_right = '0;
    step(); step();
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_flags", {data_valid, frame_start, pcm_overrun, adc_overrun}, 32'h0);
    chk("rst_drop", 32'(drop_count), 32'h0);
    reset = 1'b0; enable = 1'b1; rf_valid = 1'b1;
    // frame 0: empty side-channel
    goto(0);
    chk("f0_w0", 32'(data_out), 32'h8155);
    chk("f0_fs", 32'(frame_start), 32'h1);
    goto(1);
    chk("f0_w1", 32'(data_out), 32'h0155);
    chk("f0_fs1", 32'(frame_start), 32'h0);
    goto(14);
    chk("f0_w14", 32'(data_out), 32'h8155);
    goto(20);
    pcm_ready = 1'b1; pcm_left = 24'hABCDEF; pcm_right = 24'h123456;
    step();
    pcm_ready = 1'b0;
    // frame 1: fresh PCM pair
    goto(0);
    chk("f1_w0", 32'(data_out), 32'h8555);
    goto(1);
    chk("f1_w1", 32'(data_out), 32'h8155);
    goto(2);
    chk("f1_w2", 32'(data_out), 32'hA955);
    goto(3);
    chk("f1_w3", 32'(data_out), 32'hF155);
    goto(4);
    chk("f1_w4", 32'(data_out), 32'hDD55);
    goto(5);
    chk("f1_w5", 32'(data_out), 32'hBD55);
    goto(6);
    chk("f1_w6", 32'(data_out), 32'h1155);
    rf_valid = 1'b0; rf_in = 10'h0AA;
    step();
    chk("gap_dv", 32'(data_valid), 32'h0);
    chk("gap_hold", 32'(data_out), 32'h1155);
    rf_valid = 1'b1;
    step();
    chk("gap_w7", 32'(data_out), 32'h8CAA);
    chk("gap_dv1", 32'(data_valid), 32'h1);
    rf_in = 10'h155;
    step();
    chk("gap_w8", 32'(data_out), 32'h4555);
    goto(9);
    chk("f1_w9", 32'(data_out), 32'h5955);
    goto(14);
    chk("f1_csum", 32'(data_out), 32'hBD55);
    goto(30);
    adc_ready = 1'b1; adc_left = 12'h123; adc_right = 12'h456;
    step();
    adc_ready = 1'b0;
    goto(40);
    adc_ready = 1'b1; adc_left = 12'hABC; adc_right = 12'hDEF;
    step();
    adc_ready = 1'b0;
    chk("ovr_adc", 32'(adc_overrun), 32'h1);
    chk("ovr_pcm", 32'(pcm_overrun), 32'h0);
    chk("ovr_drop", 32'(drop_count), 32'h1);
    // frame 2: stale PCM, second ADC pair
    goto(1);
    chk("f2_w1", 32'(data_out), 32'h5155);
    goto(2);
    chk("f2_stale", 32'(data_out), 32'hA955);
    goto(10);
    chk("f2_w10", 32'(data_out), 32'hA955);
    goto(13);
    chk("f2_w13", 32'(data_out), 32'hBD55);
    goto(100);
    adc_ready = 1'b1; adc_left = 12'h111; adc_right = 12'h222;
    step();
    adc_ready = 1'b0;
    goto(511);
    adc_ready = 1'b1; adc_left = 12'h333; adc_right = 12'h444;
    step();
    adc_ready = 1'b0;
    chk("f3_w0", 32'(data_out), 32'h8D55);
    goto(1);
    chk("f3_w1", 32'(data_out), 32'h5155);
    goto(10);
    chk("f3_old", 32'(data_out), 32'h1155);
    chk("head_drop", 32'(drop_count), 32'h1);
    goto(10);
    chk("f4_new", 32'(data_out), 32'h3155);
    goto(100);
    enable = 1'b0;
    nxt = 0;
    step();
    chk("dis_dv", 32'(data_valid), 32'h0);
    step(); step();
    chk("dis_dv2", 32'(data_valid), 32'h0);
    enable = 1'b1;
    step();
    chk("ren_idle", 32'(data_valid), 32'h0);
    step();
    chk("ren_w0", 32'(data_out), 32'h9155);
    chk("ren_fs", 32'(frame_start), 32'h1);
    goto(5);
    reset = 1'b1;
    step();
    chk("mid_rst_data", 32'(data_out), 32'h0);
    chk("mid_rst_flags", {data_valid, frame_start, pcm_overrun, adc_overrun}, 32'h0);
    chk("mid_rst_drop", 32'(drop_count), 32'h0);
    reset = 1'b0; enable = 1'b0;
    pcm_ready = 1'b1; adc_ready = 1'b1;
    step(); step();
    pcm_ready = 1'b0; adc_ready = 1'b0;
    step();
    chk("dual_drop", 32'(drop_count), 32'h2);
    chk("dual_ovr", {pcm_overrun, adc_overrun}, 32'h3);
    chk("idle_dv", 32'(data_valid), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
